// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 key-schedule controller.
package sm4_pkg;
  localparam int SM4_ROUNDS     = 32;
  localparam int SM4_KX_LATENCY = 32;

  typedef logic [31:0] sm4_rk_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sm4_state_e;
endpackage

// File: rtl/sm4_rr_arb2.sv
// Two-way round-robin arbiter; requester 0 wins the first contended grant after reset.
module sm4_rr_arb2 (
  input  logic       CLK_i,
  input  logic       RST_N_i,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last_gnt1;  // 1 = requester 1 was granted most recently

  always_comb begin
    gnt = req;
    if (req[0] && req[1]) gnt = last_gnt1 ? 2'b01 : 2'b10;
  end

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i)             last_gnt1 <= 1'b1;
    else if (accept && |gnt)  last_gnt1 <= gnt[1];
  end
endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-schedule controller: arbitrates two requesters, drives the expansion pipeline,
// banks the 32 round keys and serves registered readout. Optional MK cache: SM4_KEY_CACHE_EN.
module sm4_key_sched_ctrl
  import sm4_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 40
) (
  input  logic          CLK_i,
  input  logic          RST_N_i,
  input  logic          REQ0_VALID_i,
  input  logic [127:0]  REQ0_MK_i,
  output logic          REQ0_READY_o,
  input  logic          REQ1_VALID_i,
  input  logic [127:0]  REQ1_MK_i,
  output logic          REQ1_READY_o,
  output logic [127:0]  KX_MK_o,
  output logic          KX_MK_VALID_o,
  input  logic [1023:0] KX_RK_i,
  input  logic          KX_RK_READY_i,
  input  logic [4:0]    RK_IDX_i,
  input  logic          RK_DEC_i,
  output logic [31:0]   RK_o,
  output logic          RK_VALID_o,
  output logic          RK_OWNER_o,
  output logic          BUSY_o,
  output logic          DONE_o,
  output logic          DONE_ID_o,
  output logic          TIMEOUT_o
);
  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  // Counter starts one cycle after the issue strobe and the pulse is registered,
  // so deciding at WAIT_TIMEOUT-2 puts TIMEOUT_o exactly WAIT_TIMEOUT cycles after issue.
  localparam logic [CW-1:0] CNT_LIM = CW'(WAIT_TIMEOUT - 2);

  sm4_state_e                   state;
  logic [CW-1:0]                cnt;
  logic                         owner;
  sm4_rk_t [SM4_ROUNDS-1:0]     bank;
  logic [1:0]                   gnt;
  logic                         idle, accept, gnt_id, hit;
  logic [127:0]                 acc_mk;
  logic [4:0]                   sel;

  assign idle   = (state == ST_IDLE);
  assign accept = idle && RST_N_i && (REQ0_VALID_i || REQ1_VALID_i);
  assign gnt_id = gnt[1];
  assign acc_mk = gnt_id ? REQ1_MK_i : REQ0_MK_i;
  assign BUSY_o = !idle;
  assign {REQ1_READY_o, REQ0_READY_o} = (idle && RST_N_i) ? gnt : 2'b00;

  sm4_rr_arb2 u_arb (
    .CLK_i   (CLK_i),
    .RST_N_i (RST_N_i),
    .req     ({REQ1_VALID_i, REQ0_VALID_i}),
    .accept  (accept),
    .gnt     (gnt)
  );

`ifdef SM4_KEY_CACHE_EN
  logic [127:0] cache_mk;
  logic         cache_vld;
  assign hit = cache_vld && RK_VALID_o && (acc_mk == cache_mk);

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      cache_mk  <= '0;
      cache_vld <= 1'b0;
    end else if (state == ST_WAIT && KX_RK_READY_i) begin
      cache_mk  <= KX_MK_o;
      cache_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      owner         <= 1'b0;
      KX_MK_o       <= '0;
      KX_MK_VALID_o <= 1'b0;
      RK_VALID_o    <= 1'b0;
      RK_OWNER_o    <= 1'b0;
      DONE_o        <= 1'b0;
      DONE_ID_o     <= 1'b0;
      TIMEOUT_o     <= 1'b0;
    end else begin
      KX_MK_VALID_o <= 1'b0;
      DONE_o        <= 1'b0;
      DONE_ID_o     <= 1'b0;
      TIMEOUT_o     <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          owner <= gnt_id;
          if (hit) begin
            RK_OWNER_o <= gnt_id;
            DONE_o     <= 1'b1;
            DONE_ID_o  <= gnt_id;
            state      <= ST_DONE;
          end else begin
            RK_VALID_o    <= 1'b0;
            KX_MK_o       <= acc_mk;
            KX_MK_VALID_o <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (KX_RK_READY_i) begin
            RK_VALID_o <= 1'b1;
            RK_OWNER_o <= owner;
            DONE_o     <= 1'b1;
            DONE_ID_o  <= owner;
            state      <= ST_DONE;
          end else if (cnt == CNT_LIM) begin
            TIMEOUT_o <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bank contents are only observable through RK_VALID_o, so they need no reset.
  always_ff @(posedge CLK_i) begin
    if (state == ST_WAIT && KX_RK_READY_i) bank <= KX_RK_i;
  end

  // rk[i] lives in bank[31-i]; decryption order rk[31-idx] is therefore bank[idx].
  assign sel = RK_DEC_i ? RK_IDX_i : ~RK_IDX_i;

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) RK_o <= '0;
    else          RK_o <= RK_VALID_o ? bank[sel] : '0;
  end
endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Self-checking bench for sm4_key_sched_ctrl: table-driven readout plus scoreboarded sequences.
module tb_sm4_key_sched_ctrl;
  localparam int WT = 40;
  localparam logic [127:0] GOLD = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic          CLK_i, RST_N_i;
  logic          REQ0_VALID_i, REQ1_VALID_i, REQ0_READY_o, REQ1_READY_o;
  logic [127:0]  REQ0_MK_i, REQ1_MK_i, KX_MK_o;
  logic          KX_MK_VALID_o, KX_RK_READY_i;
  logic [1023:0] KX_RK_i;
  logic [4:0]    RK_IDX_i;
  logic          RK_DEC_i;
  logic [31:0]   RK_o;
  logic          RK_VALID_o, RK_OWNER_o, BUSY_o, DONE_o, DONE_ID_o, TIMEOUT_o;

  sm4_key_sched_ctrl #(.WAIT_TIMEOUT(WT)) dut (
    .CLK_i(CLK_i), .RST_N_i(RST_N_i),
    .REQ0_VALID_i(REQ0_VALID_i), .REQ0_MK_i(REQ0_MK_i), .REQ0_READY_o(REQ0_READY_o),
    .REQ1_VALID_i(REQ1_VALID_i), .REQ1_MK_i(REQ1_MK_i), .REQ1_READY_o(REQ1_READY_o),
    .KX_MK_o(KX_MK_o), .KX_MK_VALID_o(KX_MK_VALID_o),
    .KX_RK_i(KX_RK_i), .KX_RK_READY_i(KX_RK_READY_i),
    .RK_IDX_i(RK_IDX_i), .RK_DEC_i(RK_DEC_i), .RK_o(RK_o),
    .RK_VALID_o(RK_VALID_o), .RK_OWNER_o(RK_OWNER_o), .BUSY_o(BUSY_o),
    .DONE_o(DONE_o), .DONE_ID_o(DONE_ID_o), .TIMEOUT_o(TIMEOUT_o)
  );

  initial CLK_i = 1'b0;
  always #5 CLK_i = ~CLK_i;

  int cyc = 0;
  always @(posedge CLK_i) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int exp_lat = 34;
  bit exp_to  = 0;
  typedef struct { int id; int due; bit to; } exp_t;
  exp_t sbq[$];
  int   grants[$];
  int   issues = 0, kx_lat = 32, due_rdy = -1;
  bit   kx_en = 1;

  typedef struct { logic [4:0] idx; logic dec; logic [31:0] exp; } rd_t;
  rd_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference expansion output: standard SM4 end words for the test key, distinct filler elsewhere.
  function automatic logic [31:0] rkm(input logic [127:0] mk, input int i);
    if (mk == GOLD && i == 0)  return 32'hF12186F9;
    if (mk == GOLD && i == 31) return 32'h9124A012;
    return mk[31:0] ^ mk[95:64] ^ (32'(i) * 32'h9E3779B9) ^ 32'(i);
  endfunction

  function automatic logic [1023:0] build(input logic [127:0] mk);
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[1023-32*i -: 32] = rkm(mk, i);
    return v;
  endfunction

  // Expansion pipeline model: ready exactly kx_lat cycles after the issue strobe.
  initial begin
    KX_RK_READY_i = 1'b0;
    KX_RK_i = '0;
    forever begin
      @(posedge CLK_i); #1;
      KX_RK_READY_i = (cyc == due_rdy);
      if (KX_MK_VALID_o === 1'b1) begin
        issues++;
        if (kx_en) begin
          due_rdy = cyc + kx_lat;
          KX_RK_i = build(KX_MK_o);
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge CLK_i) begin
    if (RST_N_i) begin
      if (REQ0_READY_o || REQ1_READY_o) begin
        chk("one_ready", {63'd0, REQ0_READY_o & REQ1_READY_o}, 64'd0);
        chk("ready_in_idle", {63'd0, BUSY_o}, 64'd0);
        sbq.push_back('{id: int'(REQ1_READY_o), due: cyc + (exp_to ? WT + 1 : exp_lat), to: exp_to});
        grants.push_back(int'(REQ1_READY_o));
      end
      if (DONE_o || TIMEOUT_o) begin
        if (sbq.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_event: done=%0b timeout=%0b want none (cycle %0d)", DONE_o, TIMEOUT_o, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("evt_kind_timeout", {63'd0, TIMEOUT_o}, {63'd0, e.to});
          chk("evt_cycle", 64'(cyc), 64'(e.due));
          if (!e.to) chk("done_id", {63'd0, DONE_ID_o}, 64'(e.id));
        end
      end
    end
  end

  task automatic do_req(input int id, input logic [127:0] mk);
    bit got;
    got = 0;
    @(posedge CLK_i); #1;
    if (id == 0) begin REQ0_VALID_i = 1; REQ0_MK_i = mk; end
    else         begin REQ1_VALID_i = 1; REQ1_MK_i = mk; end
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge CLK_i);
      got = (id == 0) ? REQ0_READY_o : REQ1_READY_o;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL accept_wait: req%0d READY=0 want 1 within 100 cycles", id);
    end
    @(posedge CLK_i); #1;
    REQ0_VALID_i = 0; REQ1_VALID_i = 0;
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge CLK_i);
      ok = (sbq.size() == 0) && (BUSY_o === 1'b0);
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL quiet_wait: busy=%0b pending=%0d want 0/0", BUSY_o, sbq.size());
    end
  endtask

  task automatic read_rk(input logic [4:0] idx, input logic dec, output logic [31:0] v);
    @(posedge CLK_i); #1;
    RK_IDX_i = idx; RK_DEC_i = dec;
    @(posedge CLK_i);
    @(negedge CLK_i);
    v = RK_o;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     {63'd0, BUSY_o},        64'd0);
    chk({tag, "_rkvalid"},  {63'd0, RK_VALID_o},    64'd0);
    chk({tag, "_owner"},    {63'd0, RK_OWNER_o},    64'd0);
    chk({tag, "_kxvalid"},  {63'd0, KX_MK_VALID_o}, 64'd0);
    chk({tag, "_kxmk_lo"},  KX_MK_o[63:0],          64'd0);
    chk({tag, "_kxmk_hi"},  KX_MK_o[127:64],        64'd0);
    chk({tag, "_rk"},       {32'd0, RK_o},          64'd0);
    chk({tag, "_done"},     {62'd0, DONE_o, DONE_ID_o}, 64'd0);
    chk({tag, "_timeout"},  {63'd0, TIMEOUT_o},     64'd0);
    chk({tag, "_ready"},    {62'd0, REQ1_READY_o, REQ0_READY_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int iss0;
    tbl[0] = '{5'd0,  1'b0, 32'hF12186F9};
    tbl[1] = '{5'd0,  1'b1, 32'h9124A012};
    tbl[2] = '{5'd31, 1'b0, 32'h9124A012};
    tbl[3] = '{5'd31, 1'b1, 32'hF12186F9};
    tbl[4] = '{5'd1,  1'b0, rkm(GOLD, 1)};
    tbl[5] = '{5'd30, 1'b1, rkm(GOLD, 1)};
    tbl[6] = '{5'd5,  1'b1, rkm(GOLD, 26)};
    tbl[7] = '{5'd17, 1'b0, rkm(GOLD, 17)};

    RST_N_i = 0; REQ0_VALID_i = 0; REQ1_VALID_i = 0;
    REQ0_MK_i = '0; REQ1_MK_i = '0; RK_IDX_i = '0; RK_DEC_i = 0;
    repeat (3) @(posedge CLK_i);
    @(negedge CLK_i);
    chk_all_zero("reset");
    @(posedge CLK_i); #1 RST_N_i = 1;

    // Golden key on requester 0, full-latency expansion, then table readout.
    exp_lat = 34; exp_to = 0;
    do_req(0, GOLD);
    wait_quiet();
    chk("gold_rkvalid", {63'd0, RK_VALID_o}, 64'd1);
    chk("gold_owner",   {63'd0, RK_OWNER_o}, 64'd0);
    chk("gold_kxmk",    KX_MK_o[63:0], GOLD[63:0]);
    foreach (tbl[i]) begin
      read_rk(tbl[i].idx, tbl[i].dec, v);
      chk($sformatf("rk_idx%0d_dec%0d", tbl[i].idx, tbl[i].dec), {32'd0, v}, {32'd0, tbl[i].exp});
    end

    // Reset in WAIT cycle 10; the model's late ready pulse must be ignored.
    do_req(0, 128'hA5A5_0001_0002_0003_0004_0005_0006_0007);
    repeat (11) @(posedge CLK_i);
    #1 RST_N_i = 0;
    repeat (2) @(posedge CLK_i);
    #1 RST_N_i = 1;
    sbq.delete();
    for (int k = 0; k < 60 && cyc <= due_rdy + 3; k++) @(posedge CLK_i);
    @(negedge CLK_i);
    chk_all_zero("post_reset");

    // Both requesters valid continuously: pointer restarted at requester 0.
    grants.delete();
    @(posedge CLK_i); #1;
    REQ0_MK_i = 128'h1111; REQ1_MK_i = 128'h2222;
    REQ0_VALID_i = 1; REQ1_VALID_i = 1;
    for (int k = 0; k < 400 && grants.size() < 4; k++) @(negedge CLK_i);
    @(posedge CLK_i); #1;
    REQ0_VALID_i = 0; REQ1_VALID_i = 0;
    wait_quiet();
    chk("rr_count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), 64'((i < grants.size()) ? grants[i] : 9), 64'(i % 2));

    // No ready from the pipeline: abort WT cycles after issue, next request still served.
    kx_en = 0; exp_to = 1;
    do_req(1, 128'hDEAD_BEEF);
    wait_quiet();
    kx_en = 1; exp_to = 0;
    chk("to_rkvalid", {63'd0, RK_VALID_o}, 64'd0);
    read_rk(5'd0, 1'b0, v);
    chk("to_rk_zero", {32'd0, v}, 64'd0);
    do_req(0, GOLD);
    wait_quiet();
    chk("after_to_rkvalid", {63'd0, RK_VALID_o}, 64'd1);

    // Ready on the last legal WAIT cycle is taken; one cycle later it is too late.
    kx_lat = WT - 1; exp_lat = WT + 1;
    do_req(1, 128'hE0E0_E0E0);
    wait_quiet();
    chk("edge_rkvalid", {63'd0, RK_VALID_o}, 64'd1);
    chk("edge_owner",   {63'd0, RK_OWNER_o}, 64'd1);
    kx_lat = WT; exp_to = 1;
    do_req(0, 128'hF0F0_F0F0);
    wait_quiet();
    repeat (3) @(negedge CLK_i);
    chk("late_rkvalid", {63'd0, RK_VALID_o}, 64'd0);
    chk("late_busy",    {63'd0, BUSY_o},     64'd0);
    kx_lat = 32; exp_to = 0; exp_lat = 34;

    // Repeat of the same master key: cache hit when enabled, full expansion otherwise.
    do_req(0, 128'h7777_6666_5555_4444);
    wait_quiet();
    iss0 = issues;
`ifdef SM4_KEY_CACHE_EN
    exp_lat = 1;
`else
    exp_lat = 34;
`endif
    do_req(1, 128'h7777_6666_5555_4444);
    wait_quiet();
`ifdef SM4_KEY_CACHE_EN
    chk("repeat_issues", 64'(issues - iss0), 64'd0);
`else
    chk("repeat_issues", 64'(issues - iss0), 64'd1);
`endif
    chk("repeat_owner",   {63'd0, RK_OWNER_o}, 64'd1);
    chk("repeat_rkvalid", {63'd0, RK_VALID_o}, 64'd1);
    read_rk(5'd3, 1'b0, v);
    chk("repeat_rk3", {32'd0, v}, {32'd0, rkm(128'h7777_6666_5555_4444, 3)});

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sm4_key_sched_ctrl.md
SM4_KEY_SCHED_CTRL -- requirements
Module: sm4_key_sched_ctrl

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 40, giving the max cycles from ISSUE to KX_RK_READY_i before abort.
REQ-002 SHALL have one clock; reset is synchronous and active-low; ports are CLK_i and RST_N_i.
REQ-003 CLK_i  in  1  clock; all state updates on rising edge.
REQ-004 RST_N_i  in  1  synchronous active-low reset.
REQ-005 REQ0_VALID_i  in  1  requester 0 wants a key expansion; REQ0_MK_i  in  128  its master key; REQ0_READY_o  out  1  acceptance pulse.
REQ-006 REQ1_VALID_i / REQ1_MK_i / REQ1_READY_o: same as REQ-005 for requester 1.
REQ-007 KX_MK_o  out  128  master key to the key-expansion pipeline; KX_MK_VALID_o  out  1  one-cycle issue strobe.
REQ-008 KX_RK_i  in  1024  expanded keys; rk[i] = KX_RK_i[1023-32*i -: 32]; KX_RK_READY_i  in  1  expansion complete.
REQ-009 RK_IDX_i  in  5  round index; RK_DEC_i  in  1  1 = decryption order; RK_o  out  32  selected round key.
REQ-010 RK_VALID_o  out  1  bank holds valid keys; RK_OWNER_o  out  1  requester owning bank; BUSY_o  out  1  not IDLE.
REQ-011 DONE_o  out  1  one-cycle completion pulse; DONE_ID_o  out  1  requester served; TIMEOUT_o  out  1  one-cycle abort pulse.

Function
REQ-012 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; BUSY_o = (state != IDLE).
REQ-013 IDLE: if any REQx_VALID_i, grant one, pulse its REQx_READY_o in that cycle, latch its MK, set owner id, clear RK_VALID_o, go to ISSUE.
REQ-014 Arbitration SHALL be two-way round robin: both valid -> grant the one not last granted; after reset requester 0 has priority.
REQ-015 REQx_READY_o SHALL never be asserted outside IDLE, and never for both requesters in one cycle.
REQ-016 ISSUE: KX_MK_VALID_o = 1 for exactly one cycle, then WAIT with cycle counter cleared.
REQ-017 KX_MK_o SHALL hold the latched key unchanged from ISSUE until WAIT is exited; otherwise hold last value.
REQ-018 WAIT: on KX_RK_READY_i = 1, capture all 32 rk words into the bank, set RK_VALID_o = 1, RK_OWNER_o = owner, go to DONE.
REQ-019 Pipeline latency is 32: issue in cycle c -> KX_RK_READY_i in c+32 -> DONE_o in c+33; accept at T gives DONE_o at T+34.
REQ-020 WAIT: when counter reaches WAIT_TIMEOUT without ready, pulse TIMEOUT_o, leave RK_VALID_o = 0, return to IDLE; no DONE_o.
REQ-021 DONE: DONE_o = 1 and DONE_ID_o = owner for one cycle, then IDLE.
REQ-022 KX_RK_READY_i SHALL be ignored in every state except WAIT.
REQ-023 Readout SHALL be registered, 1-cycle latency: RK_o <= RK_VALID_o ? rk[RK_DEC_i ? 31-RK_IDX_i : RK_IDX_i] : 0.
REQ-024 Readout SHALL keep operating (old bank) while a new request is in flight only until acceptance, which invalidates the bank.
REQ-025 Counter width SHALL hold WAIT_TIMEOUT without wrap.

Reset
REQ-026 RST_N_i = 0 at a rising edge SHALL force IDLE, clear bank valid, cache valid, counter; RR pointer -> requester 0.
REQ-027 Reset values: all outputs 0, including KX_MK_o and RK_o.
REQ-028 Reset mid-expansion SHALL abandon the expansion; a late KX_RK_READY_i after reset is ignored (REQ-022).

Configuration
REQ-029 Macro SM4_KEY_CACHE_EN: when defined, the last successfully expanded MK is stored with a cache-valid bit.
REQ-030 With SM4_KEY_CACHE_EN: an accepted request whose MK equals the cached MK while RK_VALID_o = 1 SHALL skip ISSUE/WAIT, keep the bank valid, set owner, and go to DONE (DONE_o at T+1).
REQ-031 Without SM4_KEY_CACHE_EN: every request expands; no cache storage is synthesized.

Structure
REQ-032 Package sm4_pkg SHALL hold the state enum, SM4_ROUNDS = 32, SM4_KX_LATENCY = 32, and the 32-bit round-key word typedef.
REQ-033 Arbitration SHALL be one sub-module sm4_rr_arb2 (2 requests, grant vector, pointer update on accept).

Verification
REQ-034 Single req0, MK = 0123456789ABCDEFFEDCBA9876543210, model ready at issue+32 -> DONE_o at T+34, DONE_ID_o = 0, RK_IDX 0 -> rk0 = F12186F9, RK_DEC 1 idx 0 -> rk31 = 9124A012.
REQ-035 Both valid every cycle for 4 requests -> grants 0,1,0,1; no double READY; each DONE_ID_o matches grant.
REQ-036 Never assert KX_RK_READY_i -> TIMEOUT_o at ISSUE+40, RK_VALID_o = 0, next request accepted.
REQ-037 Reset asserted at WAIT cycle 10, ready pulse later -> stays IDLE, no DONE_o, all outputs 0.
REQ-038 With SM4_KEY_CACHE_EN, repeat same MK -> DONE_o at T+1, KX_MK_VALID_o stays 0; without macro -> full 34-cycle expansion.
